// File: rtl/byte_ram.sv
// Single-clock byte-lane data RAM with registered read port and a zeroing sweep after reset.
// Define BYTE_RAM_FWD_EN for write-first same-address collisions; read-first otherwise.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | sweeping zeros through every word, busy=1, requests ignored
// READY | normal operation, writes and reads accepted
module byte_ram #(
    parameter int LEN   = 10,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [LEN-1:0]     w_addr,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   w_data,
    input  logic               re,
    input  logic [LEN-1:0]     r_addr,
    output logic [WIDTH-1:0]   r_data,
    output logic               r_valid,
    output logic               busy
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << LEN;

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("byte_ram: WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    logic [LEN-1:0]   cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word;

    assign w_data = mem[w_addr];

    always_comb begin
        rd_word = mem[r_addr];
`ifdef BYTE_RAM_FWD_EN
        // write-first: enabled lanes of a same-address write bypass the array
        if (we && (w_addr == r_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    rd_word[8*i +: 8] = din[8*i +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            busy    <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    r_valid <= 1'b0;
                    cnt     <= cnt + LEN'(1);
                    if (&cnt) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy    <= 1'b0;
                    r_valid <= re;
                    if (re) begin
                        r_data <= rd_word;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; the sweep defines it. Held off while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[w_addr][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
